// File: rtl/dpram_stream_reader.sv
//==============================================================================
// Module      : dpram_stream_reader
// Description : Walks a (base, stride, count) address sequence over the read
//               port of the Q8.8 dual-port RAM. The one-cycle read latency is
//               absorbed, and the words are presented as a valid/ready stream
//               through a 2-entry buffer.
//               Optional build macro: DPRAM_READER_RELU_EN (ReLU on m_data).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dpram_stream_reader #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH-1:0] stride,
    input  logic [CWIDTH-1:0] count,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] ram_addr,
    input  logic [DWIDTH-1:0] ram_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [AWIDTH-1:0] r_ptr;
    logic [AWIDTH-1:0] r_stride;
    logic [CWIDTH-1:0] r_count;
    logic [CWIDTH-1:0] r_issued;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_done;

    logic [DWIDTH-1:0] r_fifo_data [2];
    logic [1:0]        r_fifo_last;
    logic              r_wr_idx;
    logic              r_rd_idx;
    logic [1:0]        r_fifo_cnt;

    logic              w_start_ok;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_last_hs;
    logic [DWIDTH-1:0] w_head;
    logic [DWIDTH-1:0] w_head_out;

    assign w_start_ok   = (r_state == S_IDLE) && start;
    assign m_valid      = (r_fifo_cnt != 2'd0);
    assign w_pop        = m_valid && m_ready;
    assign w_last_hs    = w_pop && m_last;

    // Occupancy the buffer will have once this cycle's pop and capture settle;
    // issuing only below 2 guarantees the in-flight word always has a slot.
    assign w_occ        = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue      = (r_state == S_RUN) && (r_issued < r_count) && (w_occ < 3'd2);
    assign w_issue_last = w_issue && ((r_issued + CWIDTH'(1)) == r_count);

    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign ram_addr     = r_ptr;

    assign w_head       = r_fifo_data[r_rd_idx];

`ifdef DPRAM_READER_RELU_EN
    assign w_head_out   = w_head[DWIDTH-1] ? '0 : w_head;
`else
    assign w_head_out   = w_head;
`endif

    // Gated with valid so an empty buffer always presents zeros.
    assign m_data       = m_valid ? w_head_out : '0;
    assign m_last       = m_valid && r_fifo_last[r_rd_idx];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && (count != '0)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_issue_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_ptr           <= '0;
            r_stride        <= '0;
            r_count         <= '0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
            r_fifo_last     <= 2'b00;
            r_wr_idx        <= 1'b0;
            r_rd_idx        <= 1'b0;
            r_fifo_cnt      <= 2'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
            r_done          <= (w_start_ok && (count == '0)) || w_last_hs;

            if (w_start_ok) begin
                r_ptr    <= base_addr;
                r_stride <= stride;
                r_count  <= count;
                r_issued <= '0;
            end else if (w_issue) begin
                r_ptr    <= r_ptr + r_stride;
                r_issued <= r_issued + CWIDTH'(1);
            end

            if (r_inflight) begin
                r_fifo_last[r_wr_idx] <= r_inflight_last;
                r_wr_idx              <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // Payload storage needs no reset: the occupancy count qualifies it.
    always_ff @(posedge clk) begin
        if (r_inflight) begin
            r_fifo_data[r_wr_idx] <= ram_out;
        end
    end

endmodule

`default_nettype wire
